// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates one captured MIPS branch per request and
// drives a registered PC redirect, a bounded flush and a taken-branch counter.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [2:0]           i_br_op,
    input  logic [31:0]          i_rs,
    input  logic [31:0]          i_rt,
    input  logic [31:0]          i_pc_plus4,
    input  logic [15:0]          i_offset,
    input  logic                 i_kill,
    output logic                 o_redirect_valid,
    output logic [31:0]          o_redirect_pc,
    output logic                 o_flush,
    output logic [CNT_WIDTH-1:0] o_taken_cnt,
    output logic                 o_bad_op
);

    // state   | meaning
    // S_IDLE  | ready for a branch request
    // S_EVAL  | captured branch is evaluated; kill may squash it here
    // S_FLUSH | redirect issued, flush held for FLUSH_CYCLES cycles
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;
    localparam logic [2:0] OP_ALW  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [2:0]             r_op;
    logic [31:0]            r_rs;
    logic [31:0]            r_rt;
    logic [31:0]            r_pc_plus4;
    logic [15:0]            r_offset;
    logic [3:0]             r_flush_cnt;
    logic                   r_redirect_valid;
    logic [31:0]            r_redirect_pc;
    logic                   r_flush;
    logic [CNT_WIDTH-1:0]   r_taken_cnt;
    logic                   r_bad_op;

    logic                   w_accept;
    logic                   w_cond;
    logic                   w_taken_go;
    logic                   w_rs_zero;
    logic [31:0]            w_target;

    assign w_accept  = i_in_valid && (r_state == S_IDLE);
    assign w_rs_zero = (r_rs == 32'd0);
    // Word offset scaled to bytes; the add wraps modulo 2^32 by construction.
    assign w_target  = r_pc_plus4 + {{14{r_offset[15]}}, r_offset, 2'b00};

    always_comb begin
        w_cond = 1'b0;
        case (r_op)
            OP_BEQ:  w_cond = (r_rs == r_rt);
            OP_BNE:  w_cond = (r_rs != r_rt);
            OP_BLEZ: w_cond = w_rs_zero || r_rs[31];
            OP_BGTZ: w_cond = !w_rs_zero && !r_rs[31];
            OP_BLTZ: w_cond = r_rs[31];
            OP_BGEZ: w_cond = !r_rs[31];
            OP_ALW:  w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken_go = (r_state == S_EVAL) && w_cond && !i_kill;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                w_next_state = w_taken_go ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op             <= 3'd0;
            r_rs             <= 32'd0;
            r_rt             <= 32'd0;
            r_pc_plus4       <= 32'd0;
            r_offset         <= 16'd0;
            r_flush_cnt      <= 4'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_taken_cnt      <= '0;
            r_bad_op         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= i_br_op;
                r_rs       <= i_rs;
                r_rt       <= i_rt;
                r_pc_plus4 <= i_pc_plus4;
                r_offset   <= i_offset;
            end
            if (r_state == S_EVAL) begin
                if (r_op == OP_RSVD) begin
                    r_bad_op <= 1'b1;
                end
                if (w_taken_go) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= w_target;
                    r_flush          <= 1'b1;
                    r_flush_cnt      <= FLUSH_LOAD;
                    if (r_taken_cnt != '1) begin
                        r_taken_cnt <= r_taken_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
            if (r_state == S_FLUSH) begin
                r_redirect_valid <= 1'b0;
                if (r_flush_cnt == 4'd0) begin
                    r_flush <= 1'b0;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                end
            end
        end
    end

    assign o_in_ready       = (r_state == S_IDLE);
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_flush;
    assign o_taken_cnt      = r_taken_cnt;
    assign o_bad_op         = r_bad_op;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: driver queues expected redirects,
// an independent monitor checks every redirect pulse and flush window.
module tb_branch_resolve_unit;

    localparam int FC = 2;
    localparam int CW = 2;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    br_op = '0;
    logic [31:0]   rs = '0;
    logic [31:0]   rt = '0;
    logic [31:0]   pc_plus4 = '0;
    logic [15:0]   offset = '0;
    logic          kill = 1'b0;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic [CW-1:0] taken_cnt;
    logic          bad_op;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   m_cnt = 0;
    logic m_bad = 1'b0;
    exp_t sb_q[$];

    branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_in_valid       (in_valid),
        .o_in_ready       (in_ready),
        .i_br_op          (br_op),
        .i_rs             (rs),
        .i_rt             (rt),
        .i_pc_plus4       (pc_plus4),
        .i_offset         (offset),
        .i_kill           (kill),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_taken_cnt      (taken_cnt),
        .o_bad_op         (bad_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kill_mode: 0 none, 1 asserted in EVAL, 2 asserted from FLUSH onward
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [15:0] off,
                         input bit exp_taken, input logic [31:0] exp_pc,
                         input int kill_mode, input bit hold_valid, input bit abort_flush);
        int n;
        bit eff;
        eff = exp_taken && (kill_mode != 1);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_issue", in_ready, 1);
        in_valid = 1'b1;
        br_op = op; rs = a; rt = b; pc_plus4 = pc; offset = off;
        if (eff) begin
            m_cnt = (m_cnt == 3) ? 3 : m_cnt + 1;
            sb_q.push_back('{exp_pc, m_cnt});
        end
        if (op == 3'd7) m_bad = 1'b1;
        @(posedge clk); #1;
        // scramble everything during EVAL; a live-sampling DUT would misbehave
        in_valid = hold_valid;
        br_op = 3'd7; rs = 32'hA5A5A5A5; rt = 32'h0; pc_plus4 = 32'hDEAD0000; offset = 16'h1234;
        kill = (kill_mode == 1);
        check("ready_in_eval", in_ready, 0);
        @(posedge clk); #1;
        kill = (kill_mode == 2);
        if (abort_flush) begin
            @(posedge clk); #1;
            check("flush_before_reset", flush, 1);
            rst_n = 1'b0;
            #1;
            check("rst_flush", flush, 0);
            check("rst_redirect_valid", redirect_valid, 0);
            check("rst_taken_cnt", taken_cnt, 0);
            check("rst_in_ready", in_ready, 1);
            m_cnt = 0;
            m_bad = 1'b0;
            in_valid = 1'b0;
            kill = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            check("ready_after_release", in_ready, 1);
            return;
        end
        n = 2;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        kill = 1'b0;
        check("ready_latency", n, eff ? 2 + FC : 2);
        check("taken_cnt", taken_cnt, m_cnt);
        check("bad_op", bad_op, m_bad);
        check("flush_idle", flush, 0);
    endtask

    // Monitor: pops the scoreboard on each redirect pulse, measures flush windows.
    initial begin : monitor
        int   run;
        logic rv_prev;
        exp_t e;
        run = 0;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
                rv_prev = 1'b0;
            end else begin
                if (redirect_valid) begin
                    check("redirect_single_cycle", rv_prev, 0);
                    check("flush_with_redirect", flush, 1);
                    if (sb_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc);
                    end else begin
                        e = sb_q.pop_front();
                        check("redirect_pc", redirect_pc, e.pc);
                        check("cnt_at_redirect", taken_cnt, e.cnt);
                    end
                end
                if (flush) begin
                    run++;
                end else if (run != 0) begin
                    check("flush_length", run, FC);
                    run = 0;
                end
                rv_prev = redirect_valid;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_redirect_valid", redirect_valid, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        check("reset_flush", flush, 0);
        check("reset_taken_cnt", taken_cnt, 0);
        check("reset_bad_op", bad_op, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //    op    rs            rt            pc_plus4      off      tk  target        kill hold abort
        issue(3'd2, 32'h00000000, 32'h0,        32'h00400004, 16'h0003, 1, 32'h00400010, 0, 0, 0);
        issue(3'd2, 32'h80000000, 32'h0,        32'h00400004, 16'h0003, 1, 32'h00400010, 0, 0, 0);
        issue(3'd2, 32'h00000001, 32'h0,        32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        issue(3'd3, 32'h00000000, 32'h0,        32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        issue(3'd3, 32'h80000000, 32'h0,        32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        issue(3'd3, 32'h00000001, 32'h0,        32'h00001000, 16'h0010, 1, 32'h00001040, 0, 0, 0);
        issue(3'd0, 32'h00000005, 32'h00000005, 32'h00400004, 16'hFFFF, 1, 32'h00400000, 0, 0, 0);
        issue(3'd1, 32'h00000005, 32'h00000005, 32'h00400004, 16'hFFFF, 0, 32'h0,        0, 0, 0);
        issue(3'd0, 32'h00000007, 32'h00000007, 32'hFFFFFFFC, 16'h0001, 1, 32'h00000000, 0, 0, 0);
        issue(3'd4, 32'hFFFFFFFF, 32'h0,        32'h00000100, 16'h8000, 1, 32'hFFFE0100, 2, 0, 0);
        issue(3'd5, 32'hFFFFFFFF, 32'h0,        32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        issue(3'd5, 32'h00000000, 32'h0,        32'h00400004, 16'h0003, 1, 32'h00400010, 1, 1, 0);
        issue(3'd1, 32'h00000001, 32'h00000002, 32'h00400000, 16'h0004, 1, 32'h00400010, 0, 1, 0);
        issue(3'd6, 32'h00000000, 32'h0,        32'h00002000, 16'h0001, 1, 32'h00002004, 0, 0, 1);

        for (int i = 1; i <= 5; i++) begin
            issue(3'd6, 32'h0, 32'h0, 32'h100 * i, 16'h0000, 1, 32'h100 * i, 0, 0, 0);
        end
        check("taken_cnt_saturated", taken_cnt, 3);

        issue(3'd7, 32'h00000000, 32'h0,        32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        issue(3'd1, 32'h00000003, 32'h00000003, 32'h00400004, 16'h0003, 0, 32'h0,        0, 0, 0);
        check("bad_op_sticky", bad_op, 1);

        rst_n = 1'b0;
        #1;
        check("bad_op_cleared", bad_op, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
